// File: rtl/m1_frame_sequencer_pkg.sv
// m1_frame_sequencer_pkg
//   Shared definitions for the telemetry frame path (sequencer, word filler,
//   serializer): FSM state encodings, frame geometry constants and the
//   pointer/group widths.
//   No ports.
package m1_frame_sequencer_pkg;

  // Sequencer FSM encodings (2 bits).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Frame geometry.
  localparam int WORDS_PER_PHRASE = 128;
  localparam int GROUPS_PER_FRAME = 32;
  localparam int PTR_W            = 7;
  localparam int GRP_W            = 5;

  // True for the states in which words are being sequenced.
  function automatic logic st_active(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/m1_word_divider.sv
// m1_word_divider
//   Word-period counter: counts 0..PERIOD-1 while enabled and wraps; clr
//   forces it back to 0 on the next edge.
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous active-low reset
//     clr    in   return the count to 0 on the next edge (wins over en)
//     en     in   advance the count on the next edge
//     wrap   out  current count is PERIOD-1 (the coming edge wraps if enabled)
//     tick0  out  count after the coming edge will be 0
//     tick1  out  count after the coming edge will be 1
//     last   out  count after the coming edge will be PERIOD-1
//   The tick/last flags look one edge ahead so the caller can register its
//   strobes and have them line up with the count value they describe.
module m1_word_divider #(
  parameter int PERIOD = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap,
  output logic tick0,
  output logic tick1,
  output logic last
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  // Next count: clear, advance with wrap, or hold.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (en) begin
      if (count == CNT_MAX) begin
        count_nxt = '0;
      end else begin
        count_nxt = count + CW'(1);
      end
    end else begin
      count_nxt = count;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  // wrap deliberately ignores clr/en: the caller derives clr from it.
  assign wrap  = (count == CNT_MAX);
  assign tick0 = (count_nxt == '0);
  assign tick1 = (count_nxt == CW'(1));
  assign last  = (count_nxt == CNT_MAX);

endmodule

// File: rtl/m1_frame_sequencer.sv
// m1_frame_sequencer
//   Generates the word/phrase/frame timing for the telemetry frame path.
//   Once run is seen, whole frames of GROUPS_PER_FRAME phrases of
//   WORDS_PER_PHRASE words are sequenced, one word every WORD_PERIOD clocks.
//   Dropping run lets the current frame finish before returning to idle.
//   Ports:
//     clk           in   system clock
//     reset         in   asynchronous active-low reset (already synchronized)
//     run           in   level request to generate frames
//     bufGetWord    out  strobe: filler latches word at bufRdPointer
//     bufRdPointer  out  word index within the phrase
//     cntGrp        out  phrase index within the frame
//     wordLoad      out  strobe one clock after bufGetWord
//     phraseStart   out  bufGetWord of word 0
//     frameDone     out  last clock of the last word of the frame
//     busy          out  frame sequencing in progress
//   Every output is a flop loaded from next-state decode, so run reaches the
//   outputs only through a register.
module m1_frame_sequencer #(
  parameter int WORD_PERIOD      = 120,
  parameter int WORDS_PER_PHRASE = 128,
  parameter int GROUPS_PER_FRAME = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       bufGetWord,
  output logic [6:0] bufRdPointer,
  output logic [4:0] cntGrp,
  output logic       wordLoad,
  output logic       phraseStart,
  output logic       frameDone,
  output logic       busy
);

  import m1_frame_sequencer_pkg::*;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WORDS_PER_PHRASE - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS_PER_FRAME - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PTR_W-1:0] ptr_nxt;
  logic [GRP_W-1:0] grp_nxt;
  logic             clr;
  logic             active;
  logic             active_nxt;
  logic             frame_end;
  logic             wrap;
  logic             tick0;
  logic             tick1;
  logic             last;

  assign active     = st_active(state);
  assign active_nxt = st_active(state_nxt);
  // Current clock is the final clock of the frame.
  assign frame_end  = active && wrap && (bufRdPointer == PTR_LAST) &&
                      (cntGrp == GRP_LAST);

  m1_word_divider #(
    .PERIOD (WORD_PERIOD)
  ) u_word_divider (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (active),
    .wrap  (wrap),
    .tick0 (tick0),
    .tick1 (tick1),
    .last  (last)
  );

  // FSM next state and pointer/group advance.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = bufRdPointer;
    grp_nxt   = cntGrp;
    clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        clr       = 1'b1;
        ptr_nxt   = '0;
        grp_nxt   = '0;
        state_nxt = run ? ST_RUN : ST_IDLE;
      end
      ST_RUN, ST_DRAIN: begin
        if ((state == ST_DRAIN) && frame_end && !run) begin
          // Frame finished with no further request: stop and clear.
          state_nxt = ST_IDLE;
          clr       = 1'b1;
          ptr_nxt   = '0;
          grp_nxt   = '0;
        end else begin
          // Otherwise keep sequencing; run only picks RUN vs DRAIN, and a
          // frame boundary wraps straight into the next frame.
          state_nxt = run ? ST_RUN : ST_DRAIN;
          if (wrap) begin
            ptr_nxt = (bufRdPointer == PTR_LAST) ? '0 : bufRdPointer + PTR_W'(1);
            if (bufRdPointer == PTR_LAST) begin
              grp_nxt = (cntGrp == GRP_LAST) ? '0 : cntGrp + GRP_W'(1);
            end else begin
              grp_nxt = cntGrp;
            end
          end else begin
            ptr_nxt = bufRdPointer;
            grp_nxt = cntGrp;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        clr       = 1'b1;
        ptr_nxt   = '0;
        grp_nxt   = '0;
      end
    endcase
  end

  // State, counters and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      bufRdPointer <= '0;
      cntGrp       <= '0;
      bufGetWord   <= 1'b0;
      wordLoad     <= 1'b0;
      phraseStart  <= 1'b0;
      frameDone    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      bufRdPointer <= ptr_nxt;
      cntGrp       <= grp_nxt;
      bufGetWord   <= active_nxt && tick0;
      wordLoad     <= active_nxt && tick1;
      phraseStart  <= active_nxt && tick0 && (ptr_nxt == '0);
      frameDone    <= active_nxt && last && (ptr_nxt == PTR_LAST) &&
                      (grp_nxt == GRP_LAST);
      busy         <= active_nxt;
    end
  end

endmodule

// File: tb/tb_m1_frame_sequencer.sv
// tb_m1_frame_sequencer
//   Directed bench for m1_frame_sequencer with WORD_PERIOD=4. Inputs change
//   and outputs are sampled on the falling clock edge. Expected outputs for
//   an active frame come from closed-form slot arithmetic: slot k counts
//   clocks since the first RUN clock.
module tb_m1_frame_sequencer;

  localparam int P     = 4;
  localparam int GRP_SLOTS = P * 128;
  localparam int FRAME = P * 128 * 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       bufGetWord;
  logic [6:0] bufRdPointer;
  logic [4:0] cntGrp;
  logic       wordLoad;
  logic       phraseStart;
  logic       frameDone;
  logic       busy;
  logic [16:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  m1_frame_sequencer #(
    .WORD_PERIOD      (P),
    .WORDS_PER_PHRASE (128),
    .GROUPS_PER_FRAME (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .bufGetWord   (bufGetWord),
    .bufRdPointer (bufRdPointer),
    .cntGrp       (cntGrp),
    .wordLoad     (wordLoad),
    .phraseStart  (phraseStart),
    .frameDone    (frameDone),
    .busy         (busy)
  );

  assign obs = {busy, frameDone, phraseStart, wordLoad, bufGetWord, cntGrp, bufRdPointer};

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at slot %0d", k);
    $fatal(1, "watchdog");
  end

  // Expected {busy,frameDone,phraseStart,wordLoad,bufGetWord,cntGrp,ptr} in slot s.
  function automatic logic [16:0] exp_vec(input int s);
    int div;
    int ptr;
    int grp;
    logic [6:0] p7;
    logic [4:0] g5;
    div = s % P;
    ptr = (s / P) % 128;
    grp = (s / GRP_SLOTS) % 32;
    p7 = 7'(ptr);
    g5 = 5'(grp);
    return {1'b1, (div == P-1 && ptr == 127 && grp == 31), (div == 0 && ptr == 0),
            (div == 1), (div == 0), g5, p7};
  endfunction

  // Advance to the next falling edge past a rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_state: observed %h required %h", obs, 17'd0);
    end
    reset = 1'b1;
    bad = 0;
    repeat (3) begin
      step();
      if (obs !== 17'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL idle_hold: %0d nonzero idle cycles, required 0", bad);
    end
  endtask

  task automatic test_startup();
    run = 1'b1;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      n_checks++;
      if (obs !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL startup_slot%0d: observed %h required %h", k, obs, exp_vec(k));
      end
      k++;
    end
  endtask

  task automatic test_full_frame();
    int bad;
    int fd_n;
    int fd_k;
    bad = 0; fd_n = 0; fd_k = -1;
    while (k < FRAME + 16) begin
      step();
      if (obs !== exp_vec(k)) bad++;
      if (frameDone) begin
        fd_n++;
        fd_k = k;
      end
      k++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL full_frame: %0d slot mismatches, required 0", bad);
    end
    n_checks++;
    if (fd_n !== 1) begin
      n_fail++;
      $display("FAIL frame_done_count: observed %0d required 1", fd_n);
    end
    n_checks++;
    if (fd_k !== FRAME - 1) begin
      n_fail++;
      $display("FAIL frame_done_slot: observed %0d required %0d", fd_k, FRAME - 1);
    end
  endtask

  task automatic test_drain();
    int bad;
    int target;
    logic [11:0] last_get;
    bad = 0;
    last_get = 12'd0;
    target = FRAME + 3 * GRP_SLOTS + 10 * P;
    while (k <= target) begin
      step();
      if (obs !== exp_vec(k)) bad++;
      k++;
    end
    run = 1'b0;
    while (k < 2 * FRAME) begin
      step();
      if (obs !== exp_vec(k)) bad++;
      if (bufGetWord) last_get = {cntGrp, bufRdPointer};
      k++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL drain_sequence: %0d slot mismatches, required 0", bad);
    end
    n_checks++;
    if (last_get !== {5'd31, 7'd127}) begin
      n_fail++;
      $display("FAIL drain_last_get: observed grp/ptr %h required %h", last_get, {5'd31, 7'd127});
    end
    step();
    n_checks++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL drain_to_idle: observed %h required %h", obs, 17'd0);
    end
    bad = 0;
    repeat (3) begin
      step();
      if (obs !== 17'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL drain_idle_hold: %0d nonzero idle cycles, required 0", bad);
    end
  endtask

  task automatic test_rerun();
    int bad;
    int gap_bad;
    int prev;
    bad = 0; gap_bad = 0; prev = -1;
    run = 1'b1;
    k = 0;
    while (k < FRAME + 8) begin
      step();
      if (obs !== exp_vec(k)) bad++;
      if (bufGetWord) begin
        if (prev >= 0 && (k - prev) != P) gap_bad++;
        prev = k;
      end
      if (k == 0) run = 1'b0;
      if (k == 20 * GRP_SLOTS) run = 1'b1;
      k++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rerun_sequence: %0d slot mismatches, required 0", bad);
    end
    n_checks++;
    if (gap_bad !== 0) begin
      n_fail++;
      $display("FAIL rerun_strobe_period: %0d irregular gaps, required 0", gap_bad);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    int target;
    bad = 0;
    target = FRAME + 7 * GRP_SLOTS + 64 * P;
    while (k <= target) begin
      step();
      if (obs !== exp_vec(k)) bad++;
      k++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL pre_reset_sequence: %0d slot mismatches, required 0", bad);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_async: observed %h required %h", obs, 17'd0);
    end
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (4) begin
      step();
      if (obs !== 17'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: %0d nonzero idle cycles, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    run = 1'b1;
    k = 0;
    step();
    n_checks++;
    if (obs !== exp_vec(0)) begin
      n_fail++;
      $display("FAIL restart_first_slot: observed %h required %h", obs, exp_vec(0));
    end
    run = 1'b0;
    k = 1;
    while (k < FRAME) begin
      step();
      if (obs !== exp_vec(k)) bad++;
      k++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL drain_frame: %0d slot mismatches, required 0", bad);
    end
    n_checks++;
    if (frameDone !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_frame_done: observed %b required 1", frameDone);
    end
    run = 1'b1;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) begin
        n_checks++;
        if (obs !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL b2b_first_get: observed %h required %h", obs, exp_vec(k));
        end
      end else begin
        if (obs !== exp_vec(k)) bad++;
      end
      k++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_following: %0d slot mismatches, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_full_frame();
    test_drain();
    test_rerun();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m1_frame_sequencer.md
M1_FRAME_SEQUENCER -- requirements
Module: m1_frame_sequencer

Interface
REQ-001 Parameter WORD_PERIOD, default 120: clocks per telemetry word; legal range 4..1023.
REQ-002 Parameter WORDS_PER_PHRASE, default 128: words per phrase; fixed by the 7-bit pointer.
REQ-003 Parameter GROUPS_PER_FRAME, default 32: phrases (groups) per frame; fixed by the 5-bit group counter.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  level request to generate frames; sampled every clk.
REQ-007 bufGetWord  output  1  one-clock strobe telling the word filler to latch the word at bufRdPointer.
REQ-008 bufRdPointer  output  7  word index within the phrase, 0..127.
REQ-009 cntGrp  output  5  phrase (group) index within the frame, 0..31.
REQ-010 wordLoad  output  1  one-clock strobe, one clk after bufGetWord; filler output is valid for the serializer.
REQ-011 phraseStart  output  1  high together with bufGetWord when bufRdPointer==0.
REQ-012 frameDone  output  1  one-clock pulse on the last clock of word 127 of group 31.
REQ-013 busy  output  1  high in RUN and DRAIN states.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DRAIN, encoded in 2 bits.
REQ-015 IDLE: the word divider, bufRdPointer and cntGrp are held at 0, and all strobes are low; run=1 moves the FSM to RUN on the next edge.
REQ-016 In RUN and DRAIN, the divider SHALL count 0..WORD_PERIOD-1 and wrap.
REQ-017 bufGetWord (registered) SHALL be high exactly in the clocks where the divider==0.
REQ-018 The first strobe SHALL occur in the first clock after entering RUN, with pointer 0 and group 0.
REQ-019 wordLoad SHALL be high in the clocks where the divider==1, i.e. exactly one clk after bufGetWord.
REQ-020 bufRdPointer and cntGrp SHALL stay stable from bufGetWord until the divider wraps.
REQ-021 bufRdPointer SHALL increment on the edge leaving divider==WORD_PERIOD-1.
REQ-022 bufRdPointer SHALL wrap 127->0, and cntGrp SHALL increment only on that wrap.
REQ-023 cntGrp SHALL wrap 31->0 on the wrap of pointer 127->0.
REQ-024 frameDone SHALL be high in the single clock where the divider==WORD_PERIOD-1, pointer==127 and cntGrp==31.
REQ-025 In RUN, run=0 SHALL move the FSM to DRAIN; sequencing continues unchanged.
REQ-026 In DRAIN, run=1 SHALL return the FSM to RUN with no gap and no counter disturbance.
REQ-027 In DRAIN, when frameDone fires with run=0, the FSM SHALL enter IDLE and clear all counters; no further bufGetWord is issued.
REQ-028 Simultaneous frameDone and run=1 in DRAIN: the FSM SHALL go to RUN and the next frame SHALL start with no idle word slot.
REQ-029 A run pulse shorter than one clk while the FSM is in RUN still yields a full frame; frames are never truncated except by reset.
REQ-030 All outputs SHALL be registered; no combinational path from run to any output.

Reset
REQ-031 Asserting reset SHALL immediately force: state IDLE, divider 0, bufRdPointer 0, cntGrp 0, bufGetWord 0, wordLoad 0, phraseStart 0, frameDone 0, busy 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; after release the FSM waits in IDLE for run.
REQ-033 Reset release SHALL be used without an internal synchronizer; the board-level reset is already synchronized.

Structure
REQ-034 A shared package SHALL hold the FSM state encodings and the constants WORDS_PER_PHRASE=128, GROUPS_PER_FRAME=32 and the pointer/group widths, for reuse by the filler and the serializer.
REQ-035 One sub-module, m1_word_divider (period counter emitting wrap, tick0 and tick1 flags), SHALL be instantiated; all other logic is flat.

Verification
REQ-036 WORD_PERIOD=4; release reset; run=1 -> bufGetWord at cycles 1,5,9..., wordLoad at cycles 2,6,10..., pointer 0,1,2...
REQ-037 Run continuously -> pointer 127->0 increments cntGrp; frameDone once every 4*128*32=16384 clks; cntGrp 31->0.
REQ-038 Drop run at pointer 10, group 3 -> busy stays high; the last bufGetWord is at pointer 127, group 31; then IDLE, busy=0, counters 0.
REQ-039 Drop run, then re-raise it at group 20 -> no gap; strobe period stays 4 clks across the frame boundary.
REQ-040 Assert reset at pointer 64, group 7 -> all outputs 0 within the same cycle; after release, no strobe until run=1, and the next frame starts at pointer 0, group 0.
REQ-041 Raise run in the same cycle as frameDone while in DRAIN -> the next bufGetWord follows exactly 1 clk later with pointer 0, group 0.
